// File: rtl/autoconfig_master.sv
// rtl/autoconfig_master.sv - Zorro II AutoConfig sequencer (host side)
// Ports:
//   CLK, RESET       clock, synchronous active-high reset
//   START            run request pulse (honoured in IDLE/DONE only)
//   BUS_REQ/ACK      one-outstanding bus-cycle handshake to the cycle generator
//   BUS_RW/ADDR      cycle direction (1=read) and 0xE800xx address
//   BUS_WDATA        write nibble (D[7:4])
//   BUS_RDATA/ERR    read nibble and timeout flag, valid with BUS_ACK
//   BUSY, DONE       run status
//   CARD_COUNT       cards given a base address this run
//   LAST_BASE        A[23:16] of the latest base written
module autoconfig_master #(
  parameter int         MAX_CARDS = 8,
  parameter logic [7:0] MEM_START = 8'h20,
  parameter logic [7:0] MEM_END   = 8'hA0,
  parameter logic [7:0] IO_START  = 8'hE9,
  parameter logic [7:0] IO_END    = 8'hF0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  output logic        BUS_REQ,
  output logic        BUS_RW,
  output logic [23:0] BUS_ADDR,
  output logic [3:0]  BUS_WDATA,
  input  logic        BUS_ACK,
  input  logic [3:0]  BUS_RDATA,
  input  logic        BUS_ERR,
  output logic        BUSY,
  output logic        DONE,
  output logic [3:0]  CARD_COUNT,
  output logic [7:0]  LAST_BASE
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_DECODE, S_ALLOC, S_WR_LO, S_WR_HI, S_SHUTUP, S_NEXT, S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  rd_idx;
  logic [7:0]  er_type;
  logic [7:0]  product;
  logic [7:0]  flags;
  logic [15:0] mfg;
  logic [8:0]  size_u;     // size in 64K units, 1..128
  logic        sel_mem;
  logic [7:0]  base;
  logic [7:0]  mem_ptr;
  logic [7:0]  io_ptr;

  // Allocation arithmetic is 9 bits wide so an 8M card or a pool near the
  // top of the map cannot wrap around and appear to fit.
  logic [8:0] ptr9;
  logic [8:0] lim9;
  logic [8:0] align9;
  logic [8:0] end9;
  logic       fits;
  logic [8:0] next_ptr;

  assign ptr9     = {1'b0, sel_mem ? mem_ptr : io_ptr};
  assign lim9     = {1'b0, sel_mem ? MEM_END : IO_END};
  assign align9   = (ptr9 + size_u - 9'd1) & ~(size_u - 9'd1);
  assign end9     = align9 + size_u;
  assign fits     = (end9 <= lim9);
  assign next_ptr = {1'b0, base} + size_u;

  // Identity registers are captured for completeness but not exported here.
  logic unused_cfg;
  assign unused_cfg = ^{product, flags, mfg, er_type[4:3], next_ptr[8]};

  // Nibble offsets 00..0A then 10..16.
  function automatic logic [7:0] rd_offset(input logic [3:0] idx);
    if (idx < 4'd6) rd_offset = {3'b000, idx, 1'b0};
    else            rd_offset = {3'b000, idx, 1'b0} + 8'h04;
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      BUS_REQ    <= 1'b0;
      BUS_RW     <= 1'b1;
      BUS_ADDR   <= 24'hE80000;
      BUS_WDATA  <= 4'h0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      CARD_COUNT <= 4'd0;
      LAST_BASE  <= 8'h00;
      mem_ptr    <= MEM_START;
      io_ptr     <= IO_START;
      rd_idx     <= 4'd0;
      er_type    <= 8'h00;
      product    <= 8'h00;
      flags      <= 8'h00;
      mfg        <= 16'h0000;
      size_u     <= 9'd1;
      sel_mem    <= 1'b0;
      base       <= 8'h00;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (START) begin
            CARD_COUNT <= 4'd0;
            DONE       <= 1'b0;
            BUSY       <= 1'b1;
            mem_ptr    <= MEM_START;
            io_ptr     <= IO_START;
            rd_idx     <= 4'd0;
            state      <= S_READ;
          end
        end

        S_READ: begin
          if (!BUS_REQ) begin
            BUS_REQ  <= 1'b1;
            BUS_RW   <= 1'b1;
            BUS_ADDR <= {16'hE800, rd_offset(rd_idx)};
          end else if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            case (rd_idx)
              4'd0:    er_type[7:4] <= BUS_RDATA;
              4'd1:    er_type[3:0] <= BUS_RDATA;
              4'd2:    product[7:4] <= ~BUS_RDATA;
              4'd3:    product[3:0] <= ~BUS_RDATA;
              4'd4:    flags[7:4]   <= ~BUS_RDATA;
              4'd5:    flags[3:0]   <= ~BUS_RDATA;
              4'd6:    mfg[15:12]   <= ~BUS_RDATA;
              4'd7:    mfg[11:8]    <= ~BUS_RDATA;
              4'd8:    mfg[7:4]     <= ~BUS_RDATA;
              default: mfg[3:0]     <= ~BUS_RDATA;
            endcase
            // er_type[7:6] is complete after the first nibble; bail out once
            // the whole er_type register has been read.
            if (BUS_ERR || (rd_idx == 4'd1 && er_type[7:6] != 2'b11)) begin
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
              state <= S_DONE;
            end else if (rd_idx == 4'd9) begin
              state <= S_DECODE;
            end else begin
              rd_idx <= rd_idx + 4'd1;
            end
          end
        end

        S_DECODE: begin
          size_u  <= (er_type[2:0] == 3'd0) ? 9'd128 : (9'd1 << (er_type[2:0] - 3'd1));
          sel_mem <= er_type[5];
          state   <= S_ALLOC;
        end

        S_ALLOC: begin
          base  <= align9[7:0];
          state <= fits ? S_WR_LO : S_SHUTUP;
        end

        S_WR_LO: begin
          if (!BUS_REQ) begin
            BUS_REQ   <= 1'b1;
            BUS_RW    <= 1'b0;
            BUS_ADDR  <= 24'hE8004A;
            BUS_WDATA <= base[3:0];
          end else if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            state   <= S_WR_HI;
          end
        end

        // A failed write still counts: the card may have latched the base.
        S_WR_HI: begin
          if (!BUS_REQ) begin
            BUS_REQ   <= 1'b1;
            BUS_RW    <= 1'b0;
            BUS_ADDR  <= 24'hE80048;
            BUS_WDATA <= base[7:4];
          end else if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            if (sel_mem) mem_ptr <= next_ptr[7:0];
            else         io_ptr  <= next_ptr[7:0];
            LAST_BASE  <= base;
            CARD_COUNT <= CARD_COUNT + 4'd1;
            state      <= S_NEXT;
          end
        end

        S_SHUTUP: begin
          if (!BUS_REQ) begin
            BUS_REQ   <= 1'b1;
            BUS_RW    <= 1'b0;
            BUS_ADDR  <= 24'hE8004C;
            BUS_WDATA <= 4'h0;
          end else if (BUS_ACK) begin
            BUS_REQ <= 1'b0;
            state   <= S_NEXT;
          end
        end

        S_NEXT: begin
          if (CARD_COUNT == 4'(MAX_CARDS)) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else begin
            rd_idx <= 4'd0;
            state  <= S_READ;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_autoconfig_master.sv
// tb/tb_autoconfig_master.sv - scoreboard bench for autoconfig_master
module tb_autoconfig_master;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        BUS_REQ;
  logic        BUS_RW;
  logic [23:0] BUS_ADDR;
  logic [3:0]  BUS_WDATA;
  logic        BUS_ACK;
  logic [3:0]  BUS_RDATA;
  logic        BUS_ERR;
  logic        BUSY;
  logic        DONE;
  logic [3:0]  CARD_COUNT;
  logic [7:0]  LAST_BASE;

  autoconfig_master dut (
    .CLK(CLK), .RESET(RESET), .START(START),
    .BUS_REQ(BUS_REQ), .BUS_RW(BUS_RW), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_ACK(BUS_ACK), .BUS_RDATA(BUS_RDATA), .BUS_ERR(BUS_ERR),
    .BUSY(BUSY), .DONE(DONE), .CARD_COUNT(CARD_COUNT), .LAST_BASE(LAST_BASE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw;
    logic [23:0] addr;
    logic [3:0]  wdata;
  } cyc_t;

  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         dly;
  } rsp_t;

  cyc_t  exp_q[$];
  rsp_t  rsp_q[$];
  int    total = 0;
  int    bad = 0;
  int    seq = 0;
  string cur_test = "reset";
  logic [7:0] offs [10] = '{8'h00, 8'h02, 8'h04, 8'h06, 8'h08, 8'h0A,
                            8'h10, 8'h12, 8'h14, 8'h16};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s/%s: got %h expected %h", cur_test, nm, act, expv);
    end
  endtask

  function automatic int next_dly();
    next_dly = seq % 3;
    seq++;
  endfunction

  task automatic push_rd(input logic [7:0] off, input logic [3:0] d, input logic e);
    exp_q.push_back('{1'b1, {16'hE800, off}, 4'h0});
    rsp_q.push_back('{d, e, next_dly()});
  endtask

  task automatic push_wr(input logic [7:0] off, input logic [3:0] d, input logic e, input int dly);
    exp_q.push_back('{1'b0, {16'hE800, off}, d});
    rsp_q.push_back('{4'h0, e, dly});
  endtask

  task automatic card(input logic [3:0] hi, input logic [3:0] lo);
    push_rd(offs[0], hi, 1'b0);
    push_rd(offs[1], lo, 1'b0);
    for (int i = 2; i < 10; i++) push_rd(offs[i], 4'h5, 1'b0);
  endtask

  task automatic cfg(input logic [7:0] b, input logic e);
    push_wr(8'h4A, b[3:0], e, next_dly());
    push_wr(8'h48, b[7:4], e, next_dly());
  endtask

  task automatic shut();
    push_wr(8'h4C, 4'h0, 1'b0, next_dly());
  endtask

  task automatic nocard();
    push_rd(8'h00, 4'h0, 1'b1);
  endtask

  // Bus responder: acks each request after its scripted delay (255 = never).
  initial begin
    rsp_t cur;
    logic waiting;
    BUS_ACK = 1'b0;
    BUS_RDATA = 4'h0;
    BUS_ERR = 1'b0;
    waiting = 1'b0;
    cur = '{4'h0, 1'b1, 0};
    forever begin
      @(negedge CLK);
      if (RESET) begin
        BUS_ACK = 1'b0;
        BUS_ERR = 1'b0;
        waiting = 1'b0;
      end else if (BUS_ACK) begin
        BUS_ACK = 1'b0;
        BUS_ERR = 1'b0;
        BUS_RDATA = 4'h0;
      end else if (BUS_REQ) begin
        if (!waiting) begin
          if (rsp_q.size() != 0) cur = rsp_q.pop_front();
          else                   cur = '{4'h0, 1'b1, 0};
          waiting = 1'b1;
        end
        if (cur.dly == 0) begin
          BUS_ACK = 1'b1;
          BUS_RDATA = cur.rdata;
          BUS_ERR = cur.err;
          waiting = 1'b0;
        end else if (cur.dly != 255) begin
          cur.dly--;
        end
      end
    end
  end

  // Monitor: every new request is checked against the scoreboard queue.
  initial begin
    logic req_prev;
    cyc_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        req_prev = 1'b0;
      end else begin
        if (BUS_REQ && !req_prev) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_cycle", {7'h0, BUS_RW, BUS_ADDR}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("bus_cycle", {3'b0, BUS_RW, BUS_ADDR, BUS_RW ? 4'h0 : BUS_WDATA},
                             {3'b0, e.rw, e.addr, e.rw ? 4'h0 : e.wdata});
          end
        end
        req_prev = BUS_REQ;
      end
    end
  end

  task automatic pulse_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic run(input string nm, input logic [3:0] cnt, input logic [7:0] last);
    logic got;
    cur_test = nm;
    pulse_start();
    chk("busy_after_start", {31'h0, BUSY}, 32'h1);
    chk("done_after_start", {31'h0, DONE}, 32'h0);
    pulse_start();  // ignored while busy
    got = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_reached", {31'h0, got}, 32'h1);
    chk("busy_at_done", {31'h0, BUSY}, 32'h0);
    chk("card_count", {28'h0, CARD_COUNT}, {28'h0, cnt});
    chk("last_base", {24'h0, LAST_BASE}, {24'h0, last});
    chk("cycles_left", exp_q.size(), 32'h0);
    exp_q.delete();
    rsp_q.delete();
  endtask

  initial begin
    logic found;
    RESET = 1'b1;
    START = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", {31'h0, BUS_REQ}, 32'h0);
    chk("rst_rw", {31'h0, BUS_RW}, 32'h1);
    chk("rst_addr", {8'h0, BUS_ADDR}, 32'h00E80000);
    chk("rst_wdata", {28'h0, BUS_WDATA}, 32'h0);
    chk("rst_busy", {31'h0, BUSY}, 32'h0);
    chk("rst_done", {31'h0, DONE}, 32'h0);
    chk("rst_count", {28'h0, CARD_COUNT}, 32'h0);
    chk("rst_last", {24'h0, LAST_BASE}, 32'h0);
    RESET = 1'b0;
    @(posedge CLK); #1;

    card(4'hC, 4'h1); cfg(8'hE9, 1'b0); nocard();
    run("one_io", 4'd1, 8'hE9);

    card(4'hC, 4'h1); cfg(8'hE9, 1'b0);
    card(4'hE, 4'h6); cfg(8'h20, 1'b0); nocard();
    run("io_and_mem", 4'd2, 8'h20);

    card(4'hE, 4'h1); cfg(8'h20, 1'b0);
    card(4'hE, 4'h6); cfg(8'h40, 1'b0); nocard();
    run("align", 4'd2, 8'h40);

    card(4'hE, 4'h7); cfg(8'h40, 1'b0);
    card(4'hE, 4'h7); shut();
    card(4'hE, 4'h6); cfg(8'h80, 1'b0);
    card(4'hE, 4'h1); shut(); nocard();
    run("overflow", 4'd2, 8'h80);

    card(4'hC, 4'h1); cfg(8'hE9, 1'b1);
    card(4'hC, 4'h1); cfg(8'hEA, 1'b0); nocard();
    run("write_err", 4'd2, 8'hEA);

    for (int i = 0; i < 7; i++) begin
      card(4'hC, 4'h1); cfg(8'hE9 + 8'(i), 1'b0);
    end
    card(4'hC, 4'h1); shut(); nocard();
    run("io_full", 4'd7, 8'hEF);

    for (int i = 0; i < 8; i++) begin
      card(4'hE, 4'h1); cfg(8'h20 + 8'(i), 1'b0);
    end
    run("max_cards", 4'd8, 8'h27);

    push_rd(8'h00, 4'h4, 1'b0); push_rd(8'h02, 4'h1, 1'b0);
    run("bad_type", 4'd0, 8'h27);

    card(4'hE, 4'h0); shut(); nocard();
    run("size_8m", 4'd0, 8'h27);

    cur_test = "reset_mid";
    card(4'hC, 4'h1);
    push_wr(8'h4A, 4'h9, 1'b0, 0);
    push_wr(8'h48, 4'hE, 1'b0, 255);
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      if (BUS_REQ && BUS_ADDR == 24'hE80048) begin
        found = 1'b1;
        break;
      end
    end
    chk("wr_hi_seen", {31'h0, found}, 32'h1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("mid_req", {31'h0, BUS_REQ}, 32'h0);
    chk("mid_busy", {31'h0, BUSY}, 32'h0);
    chk("mid_done", {31'h0, DONE}, 32'h0);
    chk("mid_count", {28'h0, CARD_COUNT}, 32'h0);
    chk("mid_addr", {8'h0, BUS_ADDR}, 32'h00E80000);
    RESET = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    @(posedge CLK); #1;
    card(4'hC, 4'h1); cfg(8'hE9, 1'b0); nocard();
    run("after_reset", 4'd1, 8'hE9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
